// File: rtl/psw_pkg.sv
// Shared definitions for the PSW flag controller: NZVC bit indices,
// branch condition codes and the controller FSM state encoding.
package psw_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_CS     = 3'b101;
  localparam logic [2:0] COND_CC     = 3'b110;
  localparam logic [2:0] COND_MI     = 3'b111;

  typedef logic [1:0] psw_state_t;
  localparam psw_state_t ST_IDLE   = 2'd0;
  localparam psw_state_t ST_ISSUE  = 2'd1;
  localparam psw_state_t ST_SETTLE = 2'd2;

endpackage

// File: rtl/psw_stack.sv
// LIFO of saved PSW values; dout shows the current top entry (zero when empty).
module psw_stack #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = $clog2(STACK_DEPTH);

  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]    sp;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign full    = (sp == PW'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = AW'(sp);
  assign top_idx = AW'(sp - PW'(1));
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

  // Storage needs no reset: entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/psw_ctrl.sv
// PSW flag controller driving external NZVC JK flip-flops, with a save/restore stack.
// Optional branch-condition evaluation is enabled by defining PSW_CTRL_COND_EN.
module psw_ctrl
  import psw_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       UPD_REQ,
  input  logic [3:0] UPD_MASK,
  input  logic [3:0] UPD_FLAGS,
  input  logic       SAVE_REQ,
  input  logic       RESTORE_REQ,
  input  logic [3:0] PSW_IN,
  output logic [3:0] J,
  output logic [3:0] K,
  output logic       READY,
  output logic       ERR,
  input  logic [2:0] COND,
  output logic       COND_TRUE
);

  psw_state_t state;
  logic [3:0] j_q;
  logic [3:0] k_q;
  logic       err_q;
  logic       idle;
  logic       push;
  logic       pop;
  logic [3:0] top;
  logic       full;
  logic       empty;

  assign idle  = (state == ST_IDLE);
  assign READY = idle;
  assign J     = j_q;
  assign K     = k_q;
  assign ERR   = err_q;

  // Stack moves at acceptance, so a reset mid-operation leaves nothing pending.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (idle) begin
      if (RESTORE_REQ) begin
        pop = !empty;
      end else if (SAVE_REQ) begin
        push = !full;
      end
    end
  end

  psw_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .WIDTH       (4)
  ) u_stack (
    .clk   (CLK),
    .rst   (CLR),
    .push  (push),
    .pop   (pop),
    .din   (PSW_IN),
    .dout  (top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= ST_IDLE;
      j_q   <= '0;
      k_q   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (RESTORE_REQ) begin
            state <= ST_ISSUE;
            if (empty) begin
              err_q <= 1'b1;
            end else begin
              j_q <= top;
              k_q <= ~top;
            end
          end else if (SAVE_REQ) begin
            state <= ST_ISSUE;
            if (full) begin
              err_q <= 1'b1;
            end
          end else if (UPD_REQ) begin
            state <= ST_ISSUE;
            j_q   <= UPD_MASK & UPD_FLAGS;
            k_q   <= UPD_MASK & ~UPD_FLAGS;
          end
        end
        ST_ISSUE: begin
          state <= ST_SETTLE;
          j_q   <= '0;
          k_q   <= '0;
        end
        ST_SETTLE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef PSW_CTRL_COND_EN
  logic cond_true;

  always_comb begin
    cond_true = 1'b0;
    case (COND)
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = PSW_IN[FLAG_Z];
      COND_NE:     cond_true = !PSW_IN[FLAG_Z];
      COND_LT:     cond_true = PSW_IN[FLAG_N] ^ PSW_IN[FLAG_V];
      COND_GE:     cond_true = !(PSW_IN[FLAG_N] ^ PSW_IN[FLAG_V]);
      COND_CS:     cond_true = PSW_IN[FLAG_C];
      COND_CC:     cond_true = !PSW_IN[FLAG_C];
      COND_MI:     cond_true = PSW_IN[FLAG_N];
      default:     cond_true = 1'b0;
    endcase
  end

  assign COND_TRUE = cond_true;
`else
  logic cond_unused;

  assign cond_unused = ^COND;
  assign COND_TRUE   = 1'b0;
`endif

endmodule

// File: tb/tb_psw_ctrl.sv
// Directed bench for psw_ctrl with a JK flag-register environment and expected-result queue.
module tb_psw_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       UPD_REQ, SAVE_REQ, RESTORE_REQ;
  logic [3:0] UPD_MASK, UPD_FLAGS;
  logic [3:0] PSW_IN;
  logic [3:0] J, K;
  logic       READY, ERR;
  logic [2:0] COND;
  logic       COND_TRUE;

  logic [3:0] flags = 4'b0101;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] fl;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] stk[$];
  logic [3:0] exp_flags = 4'b0101;
  logic       exp_err   = 1'b0;

  psw_ctrl #(.STACK_DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .UPD_REQ     (UPD_REQ),
    .UPD_MASK    (UPD_MASK),
    .UPD_FLAGS   (UPD_FLAGS),
    .SAVE_REQ    (SAVE_REQ),
    .RESTORE_REQ (RESTORE_REQ),
    .PSW_IN      (PSW_IN),
    .J           (J),
    .K           (K),
    .READY       (READY),
    .ERR         (ERR),
    .COND        (COND),
    .COND_TRUE   (COND_TRUE)
  );

  always #5 CLK = ~CLK;

  // External NZVC JK flip-flops
  always @(posedge CLK) flags <= (J & ~flags) | (~K & flags);
  assign PSW_IN = flags;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 update, 1 save, 2 restore, 3 all three requests together
  task automatic op(input int kind, input logic [3:0] m, input logic [3:0] f);
    exp_t e;
    @(negedge CLK);
    UPD_MASK  = m;
    UPD_FLAGS = f;
    UPD_REQ     = (kind == 0 || kind == 3);
    SAVE_REQ    = (kind == 1 || kind == 3);
    RESTORE_REQ = (kind == 2 || kind == 3);
    e.j = '0; e.k = '0; e.fl = exp_flags;
    if (kind >= 2) begin
      if (stk.size() > 0) begin
        e.j  = stk.pop_back();
        e.k  = ~e.j;
        e.fl = e.j;
      end else begin
        exp_err = 1'b1;
      end
    end else if (kind == 1) begin
      if (stk.size() < DEPTH) stk.push_back(exp_flags);
      else exp_err = 1'b1;
    end else begin
      e.j  = m & f;
      e.k  = m & ~f;
      e.fl = (exp_flags & ~m) | (m & f);
    end
    exp_flags = e.fl;
    exp_q.push_back(e);
    check("ready_idle", {7'd0, READY}, 8'd1);
    @(posedge CLK); #1;
    UPD_REQ = 0; SAVE_REQ = 0; RESTORE_REQ = 0;
    e = exp_q.pop_front();
    check("issue_j", {4'd0, J}, {4'd0, e.j});
    check("issue_k", {4'd0, K}, {4'd0, e.k});
    check("ready_issue", {7'd0, READY}, 8'd0);
    @(posedge CLK); #1;
    check("settle_jk", {J, K}, 8'd0);
    check("ready_settle", {7'd0, READY}, 8'd0);
    check("flags", {4'd0, PSW_IN}, {4'd0, e.fl});
    @(posedge CLK); #1;
    check("ready_back", {7'd0, READY}, 8'd1);
    check("err", {7'd0, ERR}, {7'd0, exp_err});
  endtask

  function automatic logic cond_model(input logic [2:0] c, input logic [3:0] fl);
`ifdef PSW_CTRL_COND_EN
    case (c)
      3'd0: return 1'b1;
      3'd1: return fl[2];
      3'd2: return !fl[2];
      3'd3: return fl[3] ^ fl[1];
      3'd4: return !(fl[3] ^ fl[1]);
      3'd5: return fl[0];
      3'd6: return !fl[0];
      default: return fl[3];
    endcase
`else
    return (c == 3'd7) && (fl == 4'hF) && 1'b0;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR = 1; UPD_REQ = 0; SAVE_REQ = 0; RESTORE_REQ = 0;
    UPD_MASK = 0; UPD_FLAGS = 0; COND = 0;
    #2;
    check("rst_jk", {J, K}, 8'd0);
    check("rst_err", {7'd0, ERR}, 8'd0);
    @(negedge CLK); CLR = 0; #1;
    check("rst_ready", {7'd0, READY}, 8'd1);

    op(0, 4'b1111, 4'b1010);          // full update from 0101
    op(0, 4'b1111, 4'b1111);
    op(0, 4'b0001, 4'b0000);          // masked: 1111 -> 1110
    op(0, 4'b1111, 4'b0110);
    op(1, 4'b0000, 4'b0000);          // save 0110
    op(0, 4'b1111, 4'b1001);
    op(2, 4'b0000, 4'b0000);          // restore -> 0110

    for (int i = 1; i <= 5; i++) begin
      op(0, 4'b1111, 4'(i));
      op(1, 4'b0000, 4'b0000);        // fifth save overflows
    end
    for (int i = 0; i < 5; i++) op(2, 4'b0000, 4'b0000);

    op(0, 4'b1111, 4'b1100);
    op(1, 4'b0000, 4'b0000);
    op(0, 4'b1111, 4'b0011);
    op(3, 4'b1111, 4'b0000);          // restore wins over save and update
    op(1, 4'b0000, 4'b0000);          // leave one entry for the reset check

    @(negedge CLK);
    UPD_MASK = 4'b1111; UPD_FLAGS = 4'b1000; UPD_REQ = 1;
    @(posedge CLK); #1; UPD_REQ = 0;
    @(posedge CLK); #1;               // SETTLE
    exp_flags = 4'b1000;
    CLR = 1; #1;
    check("abort_jk", {J, K}, 8'd0);
    check("abort_err", {7'd0, ERR}, 8'd0);
    @(negedge CLK); CLR = 0; #1;
    check("abort_ready", {7'd0, READY}, 8'd1);
    check("abort_jk2", {J, K}, 8'd0);
    stk.delete();
    exp_err = 1'b0;
    op(2, 4'b0000, 4'b0000);          // stack cleared by reset: empty restore

    for (int p = 0; p < 2; p++) begin
      if (p == 1) op(0, 4'b1111, 4'b0110);
      for (int c = 0; c < 8; c++) begin
        COND = 3'(c); #1;
        check("cond", {7'd0, COND_TRUE}, {7'd0, cond_model(3'(c), exp_flags)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/psw_ctrl.md
PSW_CTRL -- requirements
Module: psw_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, the number of PSW save slots (legal range 2..16).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port UPD_REQ, input, 1, flag-update request from the ALU.
REQ-005 SHALL have port UPD_MASK, input, 4, the NZVC bits to write (bit3=N, bit2=Z, bit1=V, bit0=C).
REQ-006 SHALL have port UPD_FLAGS, input, 4, the new NZVC values.
REQ-007 SHALL have ports SAVE_REQ and RESTORE_REQ, input, 1 each, the interrupt-entry push and interrupt-return pop.
REQ-008 SHALL have port PSW_IN, input, 4, the current NZVC readback from the flag flip-flops.
REQ-009 SHALL have port J, output, 4, the per-flag JK set inputs in NZVC order.
REQ-010 SHALL have port K, output, 4, the per-flag JK reset inputs in NZVC order.
REQ-011 SHALL have port READY, output, 1, high when a request can be accepted.
REQ-012 SHALL have port ERR, output, 1, a sticky stack-fault flag.
REQ-013 SHALL have port COND, input, 3, a branch condition code.
REQ-014 SHALL have port COND_TRUE, output, 1, the result of evaluating COND.

Function
REQ-015 SHALL implement the states IDLE, ISSUE and SETTLE; READY=1 only in IDLE.
REQ-016 In IDLE, a sampled request SHALL be accepted with priority RESTORE_REQ > SAVE_REQ > UPD_REQ, moving the FSM to ISSUE; unaccepted requests are dropped and the requester holds them.
REQ-017 Requests arriving while READY=0 SHALL be ignored.
REQ-018 In ISSUE, J/K SHALL be driven for exactly one cycle; the FSM then moves to SETTLE, then to IDLE.
REQ-019 In all other cycles, J and K SHALL both be 0000 (hold).
REQ-020 For an update, J SHALL equal UPD_MASK & UPD_FLAGS and K SHALL equal UPD_MASK & ~UPD_FLAGS, using values registered at acceptance.
REQ-021 For a save, PSW_IN SHALL be pushed onto the stack at acceptance and J=K=0 in ISSUE.
REQ-022 For a restore, the top entry SHALL be popped at acceptance, with J=entry and K=~entry in ISSUE.
REQ-023 The request-to-flag-visible latency SHALL be 2 cycles; the next accept is possible 3 cycles after the previous one.
REQ-024 A save with the stack full SHALL set ERR and perform no push; the FSM still runs ISSUE/SETTLE with J=K=0.
REQ-025 A restore with the stack empty SHALL set ERR and leave the flags unchanged (J=K=0).
REQ-026 ERR SHALL clear only on reset.
REQ-027 COND_TRUE SHALL be combinational from PSW_IN: 000 always, 001 Z, 010 !Z, 011 N^V, 100 !(N^V), 101 C, 110 !C, 111 N.

Reset
REQ-028 CLR=1 SHALL asynchronously force: FSM to IDLE, stack pointer to 0, J=K=0000, ERR=0, READY=1 once CLR is deasserted.
REQ-029 A reset during ISSUE or SETTLE SHALL abort the operation, leaving no partial stack change pending.

Configuration
REQ-030 With macro PSW_CTRL_COND_EN defined, REQ-027 SHALL apply.
REQ-031 Without PSW_CTRL_COND_EN, COND SHALL be ignored, COND_TRUE SHALL be tied to 0, and no evaluation logic SHALL be present.

Structure
REQ-032 Package psw_pkg SHALL hold the flag bit indices (N=3, Z=2, V=1, C=0), the condition-code constants, and the FSM state type.
REQ-033 The LIFO SHALL be a sub-module psw_stack (push, pop, data in/out, full, empty), parameterised by STACK_DEPTH.

Verification
REQ-034 Update: UPD_MASK=1111, UPD_FLAGS=1010 from flags 0101 -> ISSUE cycle J=1010, K=0101; PSW_IN=1010 two cycles after the request; READY low for 2 cycles.
REQ-035 Masked update: UPD_MASK=0001, UPD_FLAGS=0000 with flags 1111 -> J=0000, K=0001; flags become 1110.
REQ-036 Save then restore: save at flags 0110, update to 1001, restore -> restore ISSUE J=0110, K=1001; flags return to 0110.
REQ-037 Stack faults: 5 saves with STACK_DEPTH=4 -> ERR=1 after the 5th and the stack holds the first 4; then 5 restores -> the 5th sees an empty stack and flags are unchanged.
REQ-038 Priority and reset: SAVE_REQ, RESTORE_REQ and UPD_REQ high together -> restore is taken first; assert CLR during SETTLE -> J=K=0, READY=1 and ERR=0 immediately after deassertion.
REQ-039 Conditions (PSW_CTRL_COND_EN defined): flags N=1, V=0 -> COND=011 gives 1 and COND=100 gives 0; without the macro, COND_TRUE=0 for all codes.
